// File: rtl/parity_serial_rx_pkg.sv
// Shared definitions for the parity serial receiver and its transmitter peer:
// FSM state encoding and parity-mode constants.
package parity_serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_serial_rx_sync2.sv
// Two-flop synchroniser for an asynchronous idle-high serial line.
// Both flops reset to 1 so reset never looks like a start bit.
module parity_serial_rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/parity_serial_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Reports each completed frame with a one-cycle valid plus held error flags.
module parity_serial_rx
  import parity_serial_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIDX_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_W - 1);
  localparam logic              PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic rxs;

  parity_serial_rx_sync2 u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rxd),
    .sync_out (rxs)
  );

  rx_state_e          state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [BIDX_W-1:0]  bitidx_d, bitidx_q;
  logic [DATA_W-1:0]  shreg_d, shreg_q;
  logic               run_par_d, run_par_q;
  logic               perr_n_d, perr_n_q;
  logic [DATA_W-1:0]  data_d, data_q;
  logic               valid_d, valid_q;
  logic               parity_err_d, parity_err_q;
  logic               frame_err_d, frame_err_q;
  logic               busy_d, busy_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitidx_d     = bitidx_q;
    shreg_d      = shreg_q;
    run_par_d    = run_par_q;
    perr_n_d     = perr_n_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          // A start bit that has already gone high by mid-bit is line noise.
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bitidx_d  = '0;
            run_par_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d              = '0;
          shreg_d            = shreg_q >> 1;
          shreg_d[DATA_W-1]  = rxs;
          run_par_d          = run_par_q ^ rxs;
          bitidx_d           = bitidx_q + BIDX_W'(1);
          if (bitidx_q == LAST_BIT) state_d = ST_PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_q == BIT_M1) begin
          cnt_d    = '0;
          perr_n_d = run_par_q ^ rxs ^ PAR_MODE;
          state_d  = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d        = '0;
          valid_d      = 1'b1;
          data_d       = shreg_q;
          parity_err_d = perr_n_q;
          frame_err_d  = ~rxs;
          // Leaving at mid-stop gives half a bit to catch a back-to-back start.
          state_d      = rxs ? ST_IDLE : ST_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bitidx_q     <= '0;
      shreg_q      <= '0;
      run_par_q    <= 1'b0;
      perr_n_q     <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitidx_q     <= bitidx_d;
      shreg_q      <= shreg_d;
      run_par_q    <= run_par_d;
      perr_n_q     <= perr_n_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
Serial frame receiver that checks parity. It is the receiving end of the XOR parity generator and serial transmitter used in the combinational-circuit exercises. It deserialises an asynchronous line framed as 1 start, DATA_W data bits LSB-first, 1 parity bit and 1 stop bit. It recomputes parity with an XOR chain and reports data plus error flags to downstream logic.

Parameters:
DATA_W, 8, number of data bits per frame (1..16)
CLKS_PER_BIT, 4, clk cycles per serial bit; even, >= 2
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rxd  in  1  serial line, idle high, asynchronous to clk
data  out  DATA_W  last received data word, held until the next valid
valid  out  1  one-cycle pulse: data, parity_err and frame_err are updated
parity_err  out  1  parity mismatch for the word flagged by valid (held with data)
frame_err  out  1  stop bit sampled low for the word flagged by valid (held with data)
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0; synchroniser flops=1; state=IDLE; counters=0.
- rxd passes through a 2-flop synchroniser (rxs). All decisions use rxs.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rxs==0, go to START and clear cnt.
- START: cnt counts up. When cnt==CLKS_PER_BIT/2-1, sample rxs.
  - Sample 1 (glitch): return to IDLE with no output.
  - Sample 0: go to DATA, clear cnt and bitidx, clear the running parity.
- DATA: sample when cnt==CLKS_PER_BIT-1, then clear cnt.
  - Shift the sample into shreg from the MSB side, so the first bit ends in bit 0.
  - run_par ^= sample.
  - After sample number DATA_W, go to PARITY.
- PARITY: sample at the same cadence. perr_n = run_par ^ sample ^ PARITY_ODD. Go to STOP.
- STOP: sample at the same cadence.
  - On the following clk edge: valid=1, data=shreg, parity_err=perr_n, frame_err=(sample==0).
  - Next state is IDLE if the sample is 1, or BREAK if the sample is 0.
- BREAK: wait until rxs==1, then go to IDLE. Stops a low line from being read as endless frames.
- valid is high for exactly 1 cycle per completed frame. It pulses even when errors are flagged.
- Latency: valid rises 1 cycle after the stop-bit mid-sample, which is 2 extra cycles of synchroniser delay from the line edge.
- Back-to-back frames: returning to IDLE at stop mid-bit leaves half a bit time to detect the next start edge. No frame may be lost.
- rst asserted mid-frame aborts it immediately with no valid. Partial data is discarded.
- cnt width is clog2(CLKS_PER_BIT). bitidx width is clog2(DATA_W+1).

Decomposition:
- Shared package holds the state encoding constants (IDLE..BREAK, 3 bits) and the parity-mode constants EVEN=0, ODD=1.
- One natural sub-module: sync2 (2-flop synchroniser, reset value 1). The transmitter side reuses it.
- The parity XOR is one line inside this block, so no separate module.

Test Plan:
All tests use DATA_W=8, CLKS_PER_BIT=4, PARITY_ODD=0, bit period 4 clk.
- Good frame 0xA5, parity bit 0 -> one valid pulse, data=0xA5, parity_err=0, frame_err=0, busy returns to 0.
- Frame 0xA5 with parity bit 1 -> valid pulse, data=0xA5, parity_err=1, frame_err=0.
- rxd low for 1 bit-half (2 clk) then high -> no valid, state back to IDLE, busy drops within 4 clk.
- Frame 0x3C with stop bit 0, line held low 20 clk, then high, then good frame 0x81 -> first valid has frame_err=1. No valid while low. Second valid has data=0x81 and both errors 0.
- Frames 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses 44 clk apart, data 0x00 then 0xFF, no errors.
- rst pulsed during data bit 4 of a frame -> all outputs 0 immediately, no valid. A following frame 0x5A is received correctly.
